// File: rtl/bridge_top.sv
// bridge_top: AHB-lite slave to APB master bridge.
//
// Ports:
//   Hclk       - clock; all state changes on its rising edge
//   Hresetn    - synchronous reset, active-HIGH despite the name
//   Hwrite     - AHB direction (1 = write)
//   Hreadyin   - AHB bus ready
//   Haddr      - AHB address (32 bits)
//   Hwdata     - AHB write data (32 bits)
//   Htrans     - AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   Prdata     - APB read data (32 bits)
//   Hreadyout  - bridge ready, 0 inserts a wait state
//   Hresp      - AHB response (00 OKAY, 01 ERROR)
//   Hrdata     - AHB read data, combinational copy of Prdata
//   Penable, Pwrite, Pselx (one-hot, 3 bits), Paddr, Pwdata - registered APB master outputs
//
// Build option:
//   BRIDGE_ERR_RESP_EN - when defined, an active transfer to an address outside the bridge
//                        window gets a two-cycle ERROR response; otherwise it is ignored.

module bridge_top (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Prdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic        Penable,
   output logic        Pwrite,
   output logic [2:0]  Pselx,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StRead    = 3'd1;
   localparam logic [2:0] StRenable = 3'd2;
   localparam logic [2:0] StWwait   = 3'd3;
   localparam logic [2:0] StWrite   = 3'd4;
   localparam logic [2:0] StWenable = 3'd5;
`ifdef BRIDGE_ERR_RESP_EN
   localparam logic [2:0] StErr1    = 3'd6;
   localparam logic [2:0] StErr2    = 3'd7;
`endif

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;      // write address held across the data phase
   logic [2:0]  sel_q, sel_d;        // decoded select for the pending write
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [2:0]  pselx_q, pselx_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;

   logic        active;     // NONSEQ/SEQ with bus ready
   logic        in_range;
   logic        valid;
   logic [2:0]  decoded;

   assign active   = Hreadyin && Htrans[1];
   assign in_range = (Haddr >= 32'h8000_0000) && (Haddr <= 32'h8BFF_FFFF);
   assign valid    = active && in_range;

   // Each slave owns a 64 MB slice selected by Haddr[27:26].
   always_comb begin
      decoded = 3'b000;
      unique case (Haddr[27:26])
         2'b00:   decoded = 3'b001;
         2'b01:   decoded = 3'b010;
         2'b10:   decoded = 3'b100;
         default: decoded = 3'b000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      penable_d = 1'b0;
      pwrite_d  = pwrite_q;
      pselx_d   = pselx_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      case (state_q)
         StRead: begin
            state_d   = StRenable;
            penable_d = 1'b1;
         end
         StWwait: begin
            // Hwdata is valid in this AHB data-phase cycle
            state_d  = StWrite;
            paddr_d  = addr_q;
            pselx_d  = sel_q;
            pwrite_d = 1'b1;
            pwdata_d = Hwdata;
         end
         StWrite: begin
            state_d   = StWenable;
            penable_d = 1'b1;
         end
`ifdef BRIDGE_ERR_RESP_EN
         StErr1: begin
            state_d = StErr2;
         end
`endif
         default: begin
            // Ready states (IDLE, RENABLE, WENABLE, ERR2) sample a new transfer
            state_d = StIdle;
            pselx_d = 3'b000;
            if (valid) begin
               addr_d = Haddr;
               sel_d  = decoded;
               if (Hwrite) begin
                  state_d = StWwait;
               end else begin
                  // Reads go straight to the APB setup phase
                  state_d  = StRead;
                  paddr_d  = Haddr;
                  pselx_d  = decoded;
                  pwrite_d = 1'b0;
               end
            end
`ifdef BRIDGE_ERR_RESP_EN
            else if (active) begin
               state_d = StErr1;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (Hresetn) begin
         state_q   <= StIdle;
         addr_q    <= 32'h0;
         sel_q     <= 3'b000;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pselx_q   <= 3'b000;
         paddr_q   <= 32'h0;
         pwdata_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         pselx_q   <= pselx_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

`ifdef BRIDGE_ERR_RESP_EN
   assign Hreadyout = !((state_q == StRead) || (state_q == StWwait) ||
                        (state_q == StWrite) || (state_q == StErr1));
   assign Hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
`else
   assign Hreadyout = !((state_q == StRead) || (state_q == StWwait) || (state_q == StWrite));
   assign Hresp     = 2'b00;
`endif

   assign Hrdata  = Prdata;
   assign Penable = penable_q;
   assign Pwrite  = pwrite_q;
   assign Pselx   = pselx_q;
   assign Paddr   = paddr_q;
   assign Pwdata  = pwdata_q;

endmodule

// File: tb/tb_bridge_top.sv
// Testbench for bridge_top: table-driven single transfers, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level reference model.

module tb_bridge_top;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic        Hwrite;
   logic        Hreadyin;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [1:0]  Htrans;
   logic [31:0] Prdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic        Penable;
   logic        Pwrite;
   logic [2:0]  Pselx;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;

   bridge_top dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Htrans    (Htrans),
      .Prdata    (Prdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Pselx     (Pselx),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata)
   );

   always #5 Hclk = ~Hclk;

`ifdef BRIDGE_ERR_RESP_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge Hclk);
      #1;
   endtask

   task automatic idle_bus();
      Hwrite   = 1'b0;
      Hreadyin = 1'b1;
      Htrans   = 2'b00;
      Haddr    = 32'h0;
   endtask

   // Reference decode: 64 MB slices starting at 0x8000_0000.
   function automatic logic [2:0] ref_sel(input logic [31:0] a);
      if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
      return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
   endfunction

   typedef struct {
      logic        hwrite;
      logic [1:0]  htrans;
      logic        hreadyin;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic [2:0]  exp_sel;   // 000 = no APB transfer expected
   } vec_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  sel;
      int          cyc;       // cycle in which the APB access phase must appear
   } txn_t;

   vec_t vecs[12];
   txn_t q[$];
   txn_t pend;
   txn_t t;
   logic pend_valid;
   int   busy, err, now;
   int   acc;
   logic [2:0]  sel_seen;
   logic        wr_seen;
   logic [31:0] addr_seen, data_seen;
   logic        exp_acc;
   logic        ok_range;

   initial begin
      vecs[0]  = '{1'b1, 2'b10, 1'b1, 32'h8000_0001, 32'hA5A5_A5A5, 3'b001};
      vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h8000_00A2, 32'h0,         3'b001};
      vecs[2]  = '{1'b1, 2'b10, 1'b1, 32'h8400_0000, 32'h1111_2222, 3'b010};
      vecs[3]  = '{1'b1, 2'b11, 1'b1, 32'h8800_0000, 32'h3333_4444, 3'b100};
      vecs[4]  = '{1'b1, 2'b10, 1'b1, 32'h9000_0000, 32'h5555_6666, 3'b000};
      vecs[5]  = '{1'b1, 2'b01, 1'b1, 32'h8000_0000, 32'h7777_8888, 3'b000};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h8400_0000, 32'h0,         3'b000};
      vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'h9999_AAAA, 3'b000};
      vecs[8]  = '{1'b0, 2'b11, 1'b1, 32'h8BFF_FFFF, 32'h0,         3'b100};
      vecs[9]  = '{1'b1, 2'b10, 1'b1, 32'h8C00_0000, 32'hBBBB_CCCC, 3'b000};
      vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h7FFF_FFFF, 32'h0,         3'b000};
      vecs[11] = '{1'b1, 2'b10, 1'b1, 32'h87FF_FFFC, 32'hDEAD_BEEF, 3'b010};

      idle_bus();
      Hwdata  = 32'h0;
      Prdata  = 32'h0;
      Hresetn = 1'b1;
      step();
      step();

      // Reset state
      chk("rst_penable", Penable, 0);
      chk("rst_pwrite", Pwrite, 0);
      chk("rst_pselx", Pselx, 0);
      chk("rst_paddr", Paddr, 0);
      chk("rst_pwdata", Pwdata, 0);
      chk("rst_hreadyout", Hreadyout, 1);
      chk("rst_hresp", Hresp, 0);
      Hresetn = 1'b0;
      step();

      // Table-driven single transfers from IDLE
      for (int i = 0; i < 12; i++) begin
         Hwrite   = vecs[i].hwrite;
         Htrans   = vecs[i].htrans;
         Hreadyin = vecs[i].hreadyin;
         Haddr    = vecs[i].haddr;
         Prdata   = $urandom;
         step();
         idle_bus();
         Hwdata = vecs[i].hwdata;
         acc = 0;
         sel_seen = 3'b000;
         wr_seen = 1'b0;
         addr_seen = 32'h0;
         data_seen = 32'h0;
         for (int c = 0; c < 5; c++) begin
            if (Penable) begin
               acc++;
               sel_seen  = Pselx;
               wr_seen   = Pwrite;
               addr_seen = Paddr;
               data_seen = Pwdata;
            end
            step();
         end
         chk($sformatf("vec%0d_count", i), acc, (vecs[i].exp_sel != 0) ? 1 : 0);
         chk($sformatf("vec%0d_sel", i), sel_seen, vecs[i].exp_sel);
         if (vecs[i].exp_sel != 0) begin
            chk($sformatf("vec%0d_pwrite", i), wr_seen, vecs[i].hwrite);
            chk($sformatf("vec%0d_paddr", i), addr_seen, vecs[i].haddr);
            if (vecs[i].hwrite) chk($sformatf("vec%0d_pwdata", i), data_seen, vecs[i].hwdata);
         end
         chk($sformatf("vec%0d_idle_sel", i), Pselx, 0);
      end

      // Write walkthrough, cycle by cycle
      Hwrite = 1'b1; Htrans = 2'b10; Haddr = 32'h8000_0001;
      step();                                      // WWAIT
      chk("wr_wwait_ready", Hreadyout, 0);
      chk("wr_wwait_sel", Pselx, 0);
      idle_bus();
      Hwdata = 32'hA5A5_A5A5;
      step();                                      // WRITE
      chk("wr_setup_sel", Pselx, 3'b001);
      chk("wr_setup_pwrite", Pwrite, 1);
      chk("wr_setup_penable", Penable, 0);
      chk("wr_setup_paddr", Paddr, 32'h8000_0001);
      chk("wr_setup_pwdata", Pwdata, 32'hA5A5_A5A5);
      chk("wr_setup_ready", Hreadyout, 0);
      Hwdata = 32'h0;
      step();                                      // WENABLE
      chk("wr_access_penable", Penable, 1);
      chk("wr_access_ready", Hreadyout, 1);
      step();                                      // IDLE
      chk("wr_idle_sel", Pselx, 0);
      chk("wr_idle_penable", Penable, 0);
      chk("wr_idle_pwrite", Pwrite, 1);
      chk("wr_idle_paddr", Paddr, 32'h8000_0001);
      chk("wr_idle_pwdata", Pwdata, 32'hA5A5_A5A5);

      // Back-to-back: read issued during WENABLE goes straight to READ
      Hwrite = 1'b1; Htrans = 2'b10; Haddr = 32'h8400_0000;
      step();
      idle_bus();
      Hwdata = 32'h0102_0304;
      step();
      step();                                      // WENABLE
      chk("b2b_wenable", Penable, 1);
      Hwrite = 1'b0; Htrans = 2'b10; Haddr = 32'h8000_0010;
      Prdata = 32'h5A5A_5A5A;
      step();                                      // READ
      chk("b2b_read_sel", Pselx, 3'b001);
      chk("b2b_read_pwrite", Pwrite, 0);
      chk("b2b_read_penable", Penable, 0);
      chk("b2b_read_paddr", Paddr, 32'h8000_0010);
      chk("b2b_read_ready", Hreadyout, 0);
      idle_bus();
      step();                                      // RENABLE
      chk("b2b_renable", Penable, 1);
      chk("b2b_renable_sel", Pselx, 3'b001);
      chk("b2b_hrdata", Hrdata, 32'h5A5A_5A5A);
      step();
      chk("b2b_idle_sel", Pselx, 0);

      // Reset during WRITE aborts the transfer
      Hwrite = 1'b1; Htrans = 2'b10; Haddr = 32'h8800_0040;
      step();
      idle_bus();
      Hwdata = 32'hCAFE_F00D;
      step();                                      // WRITE
      chk("rstw_setup_sel", Pselx, 3'b100);
      Hresetn = 1'b1;
      step();
      Hresetn = 1'b0;
      chk("rstw_penable", Penable, 0);
      chk("rstw_pwrite", Pwrite, 0);
      chk("rstw_pselx", Pselx, 0);
      chk("rstw_paddr", Paddr, 0);
      chk("rstw_pwdata", Pwdata, 0);
      chk("rstw_ready", Hreadyout, 1);
      step();
      chk("rstw_stays_idle", Penable, 0);

      // Out-of-range write: no APB activity, ERROR only when enabled
      Hwrite = 1'b1; Htrans = 2'b10; Haddr = 32'h9000_0000;
      step();
      idle_bus();
      chk("oor_c1_hresp", Hresp, ErrEn ? 2'b01 : 2'b00);
      chk("oor_c1_ready", Hreadyout, ErrEn ? 0 : 1);
      chk("oor_c1_sel", Pselx, 0);
      step();
      chk("oor_c2_hresp", Hresp, ErrEn ? 2'b01 : 2'b00);
      chk("oor_c2_ready", Hreadyout, 1);
      chk("oor_c2_sel", Pselx, 0);
      step();
      chk("oor_c3_hresp", Hresp, 0);
      chk("oor_c3_penable", Penable, 0);

      // Randomized run against a transaction-level model
      Hresetn = 1'b1;
      step();
      Hresetn = 1'b0;
      busy = 0;
      err = 0;
      now = 0;
      pend_valid = 1'b0;
      q.delete();
      for (int i = 0; i < 1504; i++) begin
         step();
         now++;
         exp_acc = (q.size() > 0) && (q[0].cyc == now);
         chk("rnd_penable", Penable, exp_acc);
         chk("rnd_hreadyout", Hreadyout, (busy == 0) ? 1 : 0);
         chk("rnd_hresp", Hresp, (err > 0) ? 2'b01 : 2'b00);
         if (exp_acc) begin
            t = q.pop_front();
            chk("rnd_pselx", Pselx, t.sel);
            chk("rnd_paddr", Paddr, t.addr);
            chk("rnd_pwrite", Pwrite, t.wr);
            if (t.wr) chk("rnd_pwdata", Pwdata, t.data);
         end else begin
            chk("rnd_no_access_sel_or_idle", (Penable == 1'b0) ? 1 : 0, 1);
         end

         Hwrite   = $urandom_range(0, 1);
         Hreadyin = ($urandom_range(0, 7) != 0);
         Htrans   = (i >= 1500) ? 2'b00 : 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: Haddr = 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
            7: Haddr = 32'h8BFF_FFFE + $urandom_range(0, 3);
            8: Haddr = $urandom;
            default: Haddr = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8C00_0000;
         endcase
         Hwdata = $urandom;
         Prdata = $urandom;
         #1;
         chk("rnd_hrdata", Hrdata, Prdata);

         // Model update for the coming edge
         if (pend_valid) begin
            pend.data = Hwdata;
            q.push_back(pend);
            pend_valid = 1'b0;
         end
         if (err > 0) err--;
         ok_range = (Haddr >= 32'h8000_0000) && (Haddr < 32'h8C00_0000);
         if (busy > 0) begin
            busy--;
         end else if (Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11)) begin
            if (ok_range) begin
               t.wr   = Hwrite;
               t.addr = Haddr;
               t.data = 32'h0;
               t.sel  = ref_sel(Haddr);
               if (Hwrite) begin
                  t.cyc = now + 3;
                  busy = 2;
                  pend = t;
                  pend_valid = 1'b1;
               end else begin
                  t.cyc = now + 2;
                  busy = 1;
                  q.push_back(t);
               end
            end else if (ErrEn) begin
               busy = 1;
               err = 2;
            end
         end
      end
      chk("rnd_queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bridge_top.md
BRIDGE_TOP -- requirements
Module: bridge_top

Interface
REQ-001 SHALL have port Hclk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port Hresetn, input, 1 bit: reset is synchronous and active-high, despite the name.
REQ-003 SHALL have port Hwrite, input, 1 bit: AHB direction, 1 = write.
REQ-004 SHALL have port Hreadyin, input, 1 bit: AHB bus ready.
REQ-005 SHALL have port Haddr, input, 32 bits: AHB address.
REQ-006 SHALL have port Hwdata, input, 32 bits: AHB write data.
REQ-007 SHALL have port Htrans, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 SHALL have port Prdata, input, 32 bits: APB read data.
REQ-009 SHALL have port Hreadyout, output, 1 bit: bridge ready, 0 = wait state.
REQ-010 SHALL have port Hresp, output, 2 bits: AHB response.
REQ-011 SHALL have port Hrdata, output, 32 bits: AHB read data.
REQ-012 SHALL have ports Penable (1 bit), Pwrite (1 bit), Pselx (3 bits one-hot), Paddr (32 bits) and Pwdata (32 bits), all outputs forming the APB master.

Function
REQ-013 Valid transfer = Hreadyin=1 AND Htrans in {10,11} AND Haddr in [0x8000_0000, 0x8BFF_FFFF]; sampled only when Hreadyout=1.
REQ-014 Decode: 0x80xx-0x83xx -> Pselx=001; 0x84xx-0x87xx -> 010; 0x88xx-0x8Bxx -> 100.
REQ-015 FSM states: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
REQ-016 IDLE: valid read -> READ; valid write -> WWAIT; else stay in IDLE.
REQ-017 On acceptance, latch Haddr, decoded select and Hwrite.
REQ-018 READ: Paddr = latched address, Pselx = decoded value, Pwrite=0, Penable=0; then -> RENABLE.
REQ-019 RENABLE: Penable=1, Pselx held; transfer completes this cycle.
REQ-020 WWAIT: capture Hwdata; then -> WRITE.
REQ-021 WRITE: Paddr and Pselx driven, Pwrite=1, Pwdata = captured data, Penable=0; then -> WENABLE.
REQ-022 WENABLE: Penable=1; transfer completes.
REQ-023 From RENABLE or WENABLE: a new valid transfer goes directly to READ or WWAIT; otherwise -> IDLE.
REQ-024 APB outputs are registered; Penable follows the APB setup/access two-phase rule.
REQ-025 Hreadyout=1 in IDLE, RENABLE and WENABLE; 0 in READ, WWAIT and WRITE.
REQ-026 Write latency: 3 cycles from address acceptance to the APB access phase.
REQ-027 Read latency: 2 cycles from address acceptance to the APB access phase.
REQ-028 Hrdata = Prdata combinationally at all times.
REQ-029 Hresp = 00 (OKAY) except as defined in REQ-034.
REQ-030 In IDLE: Pselx=000 and Penable=0; Paddr, Pwdata and Pwrite hold their last values.
REQ-031 BUSY, IDLE, out-of-range addresses or Hreadyin=0 are ignored and cause no APB activity.

Reset
REQ-032 When Hresetn=1 at a clock edge, the FSM SHALL enter IDLE and Penable, Pwrite, Pselx, Paddr and Pwdata SHALL all be 0.
REQ-033 Reset SHALL have priority, and an in-flight APB transfer SHALL be aborted immediately; after reset Hreadyout=1 and Hresp=00.

Configuration
REQ-034 Macro BRIDGE_ERR_RESP_EN: when defined, a valid-type transfer (REQ-013 with the address outside the range) SHALL produce a two-cycle ERROR response (cycle 1: Hresp=01, Hreadyout=0; cycle 2: Hresp=01, Hreadyout=1) with no APB activity; when undefined, such transfers are ignored with Hresp=00.

Verification
REQ-035 Write: Haddr=0x8000_0001, Hwdata=0xA5A5A5A5, NONSEQ -> WRITE state with Pselx=001 and Pwrite=1; Penable=1 on the next cycle; afterwards Pwrite=1, Paddr=0x8000_0001 and Pwdata=0xA5A5A5A5 hold in IDLE.
REQ-036 Read: Prdata=0x5A5A5A5A, Haddr=0x8000_00A2, NONSEQ read -> Pselx=001, Pwrite=0, Penable in the 2nd cycle, Hrdata=0x5A5A5A5A.
REQ-037 Decode: writes to 0x8400_0000 and then 0x8800_0000 -> Pselx=010 and then 100.
REQ-038 Back-to-back: a read to 0x8000_0010 issued during WENABLE -> goes directly to READ with no IDLE cycle.
REQ-039 Out-of-range: write to 0x9000_0000 -> Pselx stays 000; Hresp=01 for 2 cycles only with BRIDGE_ERR_RESP_EN defined.
REQ-040 Reset mid-write: assert Hresetn during the WRITE state -> next edge all APB outputs are 0, state is IDLE and Hreadyout=1.
